// File: rtl/move_input_conditioner.sv
// Button front end for the frogger controller: synchronise, debounce and edge-detect five
// raw buttons, then turn direction presses into single hop pulses with a post-hop lockout.
module move_input_conditioner #(
    parameter int unsigned c_DEBOUNCE_LIMIT = 250000,
    parameter int unsigned c_HOP_LOCKOUT    = 3125000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Up_Btn,
    input  logic       i_Down_Btn,
    input  logic       i_Left_Btn,
    input  logic       i_Right_Btn,
    input  logic       i_Start_Btn,
    output logic       o_Up_Mvt,
    output logic       o_Down_Mvt,
    output logic       o_Left_Mvt,
    output logic       o_Right_Mvt,
    output logic       o_Game_Start,
    output logic [4:0] o_Btn_State
);

    localparam int unsigned DbWidth = $clog2(c_DEBOUNCE_LIMIT + 1);
    localparam int unsigned LkWidth = $clog2(c_HOP_LOCKOUT + 1);

    localparam logic [DbWidth-1:0] DbLast = DbWidth'(c_DEBOUNCE_LIMIT - 1);
    localparam logic [DbWidth-1:0] DbOne  = DbWidth'(1);
    localparam logic [LkWidth-1:0] LkLoad = LkWidth'(c_HOP_LOCKOUT);
    localparam logic [LkWidth-1:0] LkOne  = LkWidth'(1);

    localparam logic [1:0] StIdle        = 2'd0;
    localparam logic [1:0] StLockout     = 2'd1;
    localparam logic [1:0] StWaitRelease = 2'd2;

    logic [4:0]         raw;
    logic [4:0]         sync1_q;
    logic [4:0]         sync2_q;
    logic [4:0]         stable_q;
    logic [4:0]         stable_prev_q;
    logic [DbWidth-1:0] db_cnt_q [5];
    logic [4:0]         press;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [LkWidth-1:0] lock_q;
    logic [LkWidth-1:0] lock_d;
    logic [3:0]         mvt_q;
    logic [3:0]         mvt_d;
    logic               start_q;

    // Bit order {Start, Right, Left, Down, Up} matches o_Btn_State.
    assign raw = {i_Start_Btn, i_Right_Btn, i_Left_Btn, i_Down_Btn, i_Up_Btn};

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 5; i++) begin
                // Any sample that agrees with the stable level restarts the count.
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    stable_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbOne;
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        mvt_d   = '0;
        case (state_q)
            StIdle: begin
                if (|press[3:0]) begin
                    if (press[0]) begin
                        mvt_d = 4'b0001;
                    end else if (press[1]) begin
                        mvt_d = 4'b0010;
                    end else if (press[2]) begin
                        mvt_d = 4'b0100;
                    end else begin
                        mvt_d = 4'b1000;
                    end
                    lock_d  = LkLoad;
                    state_d = StLockout;
                end
            end
            StLockout: begin
                if (lock_q == '0) begin
                    state_d = StWaitRelease;
                end else begin
                    lock_d = lock_q - LkOne;
                end
            end
            StWaitRelease: begin
                if (stable_q[3:0] == 4'b0000) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= StIdle;
            lock_q  <= '0;
            mvt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            mvt_q   <= mvt_d;
            start_q <= press[4];
        end
    end

    assign o_Up_Mvt     = mvt_q[0];
    assign o_Down_Mvt   = mvt_q[1];
    assign o_Left_Mvt   = mvt_q[2];
    assign o_Right_Mvt  = mvt_q[3];
    assign o_Game_Start = start_q;
    assign o_Btn_State  = stable_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner: a history-window reference model checked every cycle,
// directed scenarios with literal pulse timings, then randomized button traffic.
module tb_move_input_conditioner;

    localparam int L = 4;
    localparam int H = 8;

    logic       clk;
    logic       rst_n;
    logic       up_btn, down_btn, left_btn, right_btn, start_btn;
    logic       up_mvt, down_mvt, left_mvt, right_mvt, game_start;
    logic [4:0] btn_state;

    int n_cmp = 0;
    int n_err = 0;
    int edge_no = 0;

    // DUT pulse log (index 0..3 = Up/Down/Left/Right, 4 = Start) and the same for the model.
    int pc [5];
    int pe [5];
    int mpc [5];
    int mpe [5];

    // Reference model state, describing values after the most recent edge.
    logic [4:0]   raw;
    logic [4:0]   d1, d2;
    logic [4:0]   st1, st2;
    logic [4:0]   m_press, m_nst;
    logic [L-1:0] win [5];
    logic [3:0]   m_mvt;
    logic         m_start;
    bit           m_idle;
    int           unlock_edge;

    move_input_conditioner #(
        .c_DEBOUNCE_LIMIT(L),
        .c_HOP_LOCKOUT   (H)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Up_Btn    (up_btn),
        .i_Down_Btn  (down_btn),
        .i_Left_Btn  (left_btn),
        .i_Right_Btn (right_btn),
        .i_Start_Btn (start_btn),
        .o_Up_Mvt    (up_mvt),
        .o_Down_Mvt  (down_mvt),
        .o_Left_Mvt  (left_mvt),
        .o_Right_Mvt (right_mvt),
        .o_Game_Start(game_start),
        .o_Btn_State (btn_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign raw = {start_btn, right_btn, left_btn, down_btn, up_btn};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic set_btns(input logic [4:0] v);
        {start_btn, right_btn, left_btn, down_btn, up_btn} = v;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            pc[i] = 0; pe[i] = -1; mpc[i] = 0; mpe[i] = -1;
        end
        d1 = '0; d2 = '0; st1 = '0; st2 = '0;
        m_mvt = '0; m_start = 1'b0; m_idle = 1'b1; unlock_edge = 0;
        for (int i = 0; i < 5; i++) win[i] = '0;
    end

    // Model: a level flips once the last L synchronised samples all disagree with it;
    // a hop is accepted only while idle, and idle returns no earlier than H+2 edges after
    // a hop, on an edge where every direction level is already low.
    always @(posedge clk) begin
        edge_no++;
        if (!rst_n) begin
            d1 = '0; d2 = '0; st1 = '0; st2 = '0;
            for (int i = 0; i < 5; i++) win[i] = '0;
            m_mvt = '0; m_start = 1'b0; m_idle = 1'b1;
        end else begin
            m_press = st1 & ~st2;
            m_start = m_press[4];
            m_mvt   = '0;
            if (m_idle) begin
                if (m_press[3:0] != 4'b0000) begin
                    for (int i = 3; i >= 0; i--) begin
                        if (m_press[i]) m_mvt = 4'b0001 << i;
                    end
                    m_idle      = 1'b0;
                    unlock_edge = edge_no + H + 2;
                end
            end else if (edge_no >= unlock_edge && st1[3:0] == 4'b0000) begin
                m_idle = 1'b1;
            end
            for (int i = 0; i < 5; i++) begin
                win[i]   = {win[i][L-2:0], d2[i]};
                m_nst[i] = (win[i] == {L{~st1[i]}}) ? ~st1[i] : st1[i];
            end
            st2 = st1;
            st1 = m_nst;
            d2  = d1;
            d1  = raw;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_mvt[i]) begin mpc[i]++; mpe[i] = edge_no; end
        end
        if (m_start) begin mpc[4]++; mpe[4] = edge_no; end

        #1;
        check("mvt", {right_mvt, left_mvt, down_mvt, up_mvt}, m_mvt);
        check("game_start", game_start, m_start);
        check("btn_state", btn_state, st1);
        check("mvt_onehot0", $onehot0({right_mvt, left_mvt, down_mvt, up_mvt}), 1);
        if (up_mvt)     begin pc[0]++; pe[0] = edge_no; end
        if (down_mvt)   begin pc[1]++; pe[1] = edge_no; end
        if (left_mvt)   begin pc[2]++; pe[2] = edge_no; end
        if (right_mvt)  begin pc[3]++; pe[3] = edge_no; end
        if (game_start) begin pc[4]++; pe[4] = edge_no; end
    end

    initial begin
        int base;
        int c0, c1, c2, c3, c4;

        // 1: reset held with every button pressed, then released.
        rst_n = 1'b0;
        set_btns(5'b11111);
        repeat (3) @(negedge clk);
        check("rst_btn_state", btn_state, 0);
        check("rst_outputs", {game_start, right_mvt, left_mvt, down_mvt, up_mvt}, 0);
        rst_n = 1'b1;
        base = edge_no + 1;
        repeat (8) @(negedge clk);
        check("t1_up_edge", pe[0], base + 6);
        check("t1_up_model_edge", mpe[0], base + 6);
        check("t1_up_count", pc[0], 1);
        check("t1_other_hops", pc[1] + pc[2] + pc[3], 0);
        check("t1_start_edge", pe[4], base + 6);
        check("t1_btn_state", btn_state, 5'b11111);
        set_btns(5'b00000);
        repeat (40) @(negedge clk);

        // 2: clean Left press held 40 cycles.
        c2 = pc[2];
        base = edge_no + 1;
        set_btns(5'b00100);
        repeat (5) @(negedge clk);
        check("t2_level_before", btn_state[2], 0);
        @(negedge clk);
        check("t2_level_after", btn_state[2], 1);
        repeat (34) @(negedge clk);
        check("t2_left_count", pc[2], c2 + 1);
        check("t2_left_edge", pe[2], base + 6);
        check("t2_left_model_edge", mpe[2], base + 6);
        set_btns(5'b00000);
        repeat (40) @(negedge clk);

        // 3: bouncing Right, four short highs then held.
        c3 = pc[3];
        for (int k = 0; k < 4; k++) begin
            set_btns(5'b01000);
            repeat (3) @(negedge clk);
            set_btns(5'b00000);
            @(negedge clk);
        end
        base = edge_no + 1;
        set_btns(5'b01000);
        repeat (20) @(negedge clk);
        check("t3_right_count", pc[3], c3 + 1);
        check("t3_right_edge", pe[3], base + 6);
        set_btns(5'b00000);
        repeat (40) @(negedge clk);

        // 4: Down and Right together, Down wins.
        c1 = pc[1];
        c3 = pc[3];
        base = edge_no + 1;
        set_btns(5'b01010);
        repeat (20) @(negedge clk);
        set_btns(5'b00000);
        repeat (40) @(negedge clk);
        check("t4_down_count", pc[1], c1 + 1);
        check("t4_down_edge", pe[1], base + 6);
        check("t4_right_count", pc[3], c3);
        check("t4_right_model_count", mpc[3], c3);

        // 5: Left press lands 3 cycles after an Up hop and is dropped; later tap is taken.
        c0 = pc[0];
        c2 = pc[2];
        base = edge_no + 1;
        set_btns(5'b00001);
        repeat (4) @(negedge clk);
        set_btns(5'b00101);
        repeat (2) @(negedge clk);
        set_btns(5'b00100);
        repeat (4) @(negedge clk);
        set_btns(5'b00000);
        repeat (30) @(negedge clk);
        check("t5_up_count", pc[0], c0 + 1);
        check("t5_up_edge", pe[0], base + 6);
        check("t5_left_dropped", pc[2], c2);
        check("t5_left_model_dropped", mpc[2], c2);
        base = edge_no + 1;
        set_btns(5'b00100);
        repeat (6) @(negedge clk);
        set_btns(5'b00000);
        repeat (30) @(negedge clk);
        check("t5_left_count", pc[2], c2 + 1);
        check("t5_left_edge", pe[2], base + 6);

        // 6: Start pressed during lockout, then reset mid-debounce of Start.
        c4 = pc[4];
        set_btns(5'b00001);
        repeat (6) @(negedge clk);
        base = edge_no + 1;
        set_btns(5'b10000);
        repeat (10) @(negedge clk);
        check("t6_start_count", pc[4], c4 + 1);
        check("t6_start_edge", pe[4], base + 6);
        set_btns(5'b00000);
        repeat (40) @(negedge clk);
        c4 = pc[4];
        set_btns(5'b10000);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        set_btns(5'b00000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_start_after_rst", pc[4], c4);
        check("t6_btn_state_clear", btn_state, 0);
        base = edge_no + 1;
        set_btns(5'b10000);
        repeat (10) @(negedge clk);
        check("t6_start_after_rst_edge", pe[4], base + 6);
        check("t6_start_after_rst_count", pc[4], c4 + 1);
        set_btns(5'b00000);
        repeat (20) @(negedge clk);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 300; k++) begin
            set_btns(5'($urandom_range(0, 31)));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 15)) @(negedge clk);
        end
        set_btns(5'b00000);
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
